// File: rtl/md_sequencer_if.sv
// rtl/md_sequencer_if.sv - E/D-stage request and HI/LO result bundle of the multiply/divide sequencer
interface md_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        md_instr_d;
  logic        busy;
  logic        done;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, abort, md_instr_d,
    input  busy, done, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, abort, md_instr_d,
    output busy, done, stall_md, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO owner and fixed-latency mult/div sequencer with MD stall term
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           rst_n,
  md_sequencer_if.slave md
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_is_md;
  logic        w_go;
  logic        w_launch;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_finish;
  logic        w_tick;

  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_den;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_md  = ~md.md_op[2];
  assign w_go     = md.start & ~md.abort;
  assign w_launch = (r_state == S_IDLE) & w_go & w_is_md;
  assign w_mthi   = (r_state == S_IDLE) & w_go & (md.md_op == 3'b100);
  assign w_mtlo   = (r_state == S_IDLE) & w_go & (md.md_op == 3'b101);
  assign w_finish = (r_state == S_RUN) & ~md.abort & (r_cnt == 5'd0);
  assign w_tick   = (r_state == S_RUN) & ~md.abort & (r_cnt != 5'd0);

  // Low 64 bits of a 64x64 product of sign-extended operands is the signed 32x32 product.
  assign w_a_sx   = {{32{md.a[31]}}, md.a};
  assign w_b_sx   = {{32{md.b[31]}}, md.b};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, md.a} * {32'd0, md.b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_div_signed = (md.md_op == 3'b010);
  assign w_a_mag = (w_div_signed & md.a[31]) ? (32'd0 - md.a) : md.a;
  assign w_b_mag = (w_div_signed & md.b[31]) ? (32'd0 - md.b) : md.b;
  assign w_den   = (md.b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_den;
  assign w_r_mag = w_a_mag % w_den;
  assign w_q     = (w_div_signed & (md.a[31] ^ md.b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r     = (w_div_signed & md.a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    if (!md.md_op[1]) begin
      {w_res_hi, w_res_lo} = md.md_op[0] ? w_prod_u : w_prod_s;
    end else if (md.b == 32'd0) begin
      w_res_hi = md.a;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      w_res_hi = w_r;
      w_res_lo = w_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;
      if (md.abort) begin
        r_cnt <= 5'd0;
      end else if (w_launch) begin
        r_cnt    <= md.md_op[1] ? DIV_LAST : MULT_LAST;
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
      end else if (w_tick) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (w_finish) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (w_mthi) begin
        r_hi <= md.a;
      end else if (w_mtlo) begin
        r_lo <= md.a;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (md.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt == 5'd0) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    md.busy     = (r_state == S_RUN);
    md.stall_md = md.md_instr_d & ((md.start & ~md.abort & w_is_md) | (r_state == S_RUN));
  end

  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule
